// File: rtl/hvac_mode_scheduler.sv
// hvac_mode_scheduler: heat/cool mode controller with hysteresis, minimum
// on-time and a mandatory both-off dead time between any two active modes.
//
// Ports:
//   clk        - clock, rising edge
//   reset      - asynchronous, active-high
//   temp       - current temperature sample (unsigned, TEMP_W bits)
//   presence   - occupant present
//   window     - window open
//   manual_off - user HVAC inhibit
//   heat_en    - heating drive (registered)
//   cool_en    - cooling drive (registered)
//   mode       - 00 IDLE, 01 HEAT, 10 COOL, 11 DEADTIME (registered)
//   switch_cnt - count of HEAT/COOL entries, wraps at 16 bits (registered)
module hvac_mode_scheduler #(
  parameter int unsigned TEMP_W  = 8,
  parameter int unsigned HEAT_ON = 18,
  parameter int unsigned COOL_ON = 26,
  parameter int unsigned HYST    = 1,
  parameter int unsigned MIN_ON  = 60,
  parameter int unsigned DEAD    = 10
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [TEMP_W-1:0] temp,
  input  logic              presence,
  input  logic              window,
  input  logic              manual_off,
  output logic              heat_en,
  output logic              cool_en,
  output logic [1:0]        mode,
  output logic [15:0]       switch_cnt
);

  // One extra bit so HEAT_ON+HYST cannot wrap.
  localparam int unsigned CMP_W  = TEMP_W + 1;
  localparam int unsigned ON_W   = $clog2(MIN_ON + 1);
  localparam int unsigned DEAD_W = $clog2(DEAD + 1);

  localparam logic [CMP_W-1:0] HEAT_ON_T  = CMP_W'(HEAT_ON);
  localparam logic [CMP_W-1:0] HEAT_OFF_T = CMP_W'(HEAT_ON + HYST);
  localparam logic [CMP_W-1:0] COOL_ON_T  = CMP_W'(COOL_ON);
  localparam logic [CMP_W-1:0] COOL_OFF_T = CMP_W'(COOL_ON - HYST);
  localparam logic [ON_W-1:0]  MIN_ON_T   = ON_W'(MIN_ON);
  localparam logic [DEAD_W-1:0] DEAD_LAST = DEAD_W'(DEAD - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_HEAT = 2'b01,
    ST_COOL = 2'b10,
    ST_DEAD = 2'b11
  } state_t;

  state_t              state, state_nxt;
  logic [ON_W-1:0]     on_cnt, on_cnt_nxt;
  logic [DEAD_W-1:0]   dead_cnt, dead_cnt_nxt;
  logic [15:0]         switch_cnt_nxt;
  logic                ok;
  logic [CMP_W-1:0]    temp_x;

  assign ok     = presence & ~window & ~manual_off;
  assign temp_x = CMP_W'(temp);

  // Next-state, counter and entry-count logic.
  always_comb begin
    state_nxt      = state;
    on_cnt_nxt     = on_cnt;
    dead_cnt_nxt   = dead_cnt;
    switch_cnt_nxt = switch_cnt;
    unique case (state)
      ST_IDLE: begin
        if (ok && (temp_x < HEAT_ON_T)) begin
          state_nxt      = ST_HEAT;
          on_cnt_nxt     = '0;
          switch_cnt_nxt = switch_cnt + 16'd1;
        end else if (ok && (temp_x > COOL_ON_T)) begin
          state_nxt      = ST_COOL;
          on_cnt_nxt     = '0;
          switch_cnt_nxt = switch_cnt + 16'd1;
        end
      end
      ST_HEAT: begin
        // Losing ok overrides the minimum on-time.
        if (!ok || ((temp_x >= HEAT_OFF_T) && (on_cnt >= MIN_ON_T))) begin
          state_nxt    = ST_DEAD;
          dead_cnt_nxt = '0;
        end else if (on_cnt < MIN_ON_T) begin
          on_cnt_nxt = on_cnt + ON_W'(1);
        end
      end
      ST_COOL: begin
        if (!ok || ((temp_x <= COOL_OFF_T) && (on_cnt >= MIN_ON_T))) begin
          state_nxt    = ST_DEAD;
          dead_cnt_nxt = '0;
        end else if (on_cnt < MIN_ON_T) begin
          on_cnt_nxt = on_cnt + ON_W'(1);
        end
      end
      ST_DEAD: begin
        // Inputs ignored; leave after exactly DEAD cycles.
        if (dead_cnt == DEAD_LAST) begin
          state_nxt    = ST_IDLE;
          dead_cnt_nxt = '0;
        end else begin
          dead_cnt_nxt = dead_cnt + DEAD_W'(1);
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // State, counters and Moore outputs decoded from the next state so the
  // drives change on the same edge as the state.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= ST_IDLE;
      on_cnt     <= '0;
      dead_cnt   <= '0;
      switch_cnt <= '0;
      heat_en    <= 1'b0;
      cool_en    <= 1'b0;
      mode       <= 2'b00;
    end else begin
      state      <= state_nxt;
      on_cnt     <= on_cnt_nxt;
      dead_cnt   <= dead_cnt_nxt;
      switch_cnt <= switch_cnt_nxt;
      heat_en    <= (state_nxt == ST_HEAT);
      cool_en    <= (state_nxt == ST_COOL);
      mode       <= state_nxt;
    end
  end

endmodule

// File: tb/tb_hvac_mode_scheduler.sv
// tb_hvac_mode_scheduler: directed self-checking bench for hvac_mode_scheduler.
// Inputs change and outputs are sampled on the falling clock edge.
module tb_hvac_mode_scheduler;

  logic        clk;
  logic        reset;
  logic [7:0]  temp;
  logic        presence;
  logic        window;
  logic        manual_off;
  logic        heat_en;
  logic        cool_en;
  logic [1:0]  mode;
  logic [15:0] sw;

  // Wide-threshold instance for the overflow case.
  logic [7:0]  b_temp;
  logic        b_presence;
  logic        b_window;
  logic        b_manual_off;
  logic        b_heat_en;
  logic        b_cool_en;
  logic [1:0]  b_mode;
  logic [15:0] b_sw;

  int n_checks;
  int n_pass;
  logic overlap_seen;

  hvac_mode_scheduler u_dut (
    .clk        (clk),
    .reset      (reset),
    .temp       (temp),
    .presence   (presence),
    .window     (window),
    .manual_off (manual_off),
    .heat_en    (heat_en),
    .cool_en    (cool_en),
    .mode       (mode),
    .switch_cnt (sw)
  );

  hvac_mode_scheduler #(
    .TEMP_W  (8),
    .HEAT_ON (250),
    .COOL_ON (300),
    .HYST    (10),
    .MIN_ON  (4),
    .DEAD    (3)
  ) u_big (
    .clk        (clk),
    .reset      (reset),
    .temp       (b_temp),
    .presence   (b_presence),
    .window     (b_window),
    .manual_off (b_manual_off),
    .heat_en    (b_heat_en),
    .cool_en    (b_cool_en),
    .mode       (b_mode),
    .switch_cnt (b_sw)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Heat and cool drives must never be on together.
  always @(negedge clk) begin
    if (heat_en && cool_en) overlap_seen = 1'b1;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp)
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    else
      n_pass++;
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    n_checks     = 0;
    n_pass       = 0;
    overlap_seen = 1'b0;
    reset        = 1'b1;
    temp         = 8'd22;
    presence     = 1'b0;
    window       = 1'b0;
    manual_off   = 1'b0;
    b_temp       = 8'd100;
    b_presence   = 1'b0;
    b_window     = 1'b0;
    b_manual_off = 1'b0;

    // Reset state
    tick(2);
    check("rst_mode", 32'(mode), 32'd0);
    check("rst_heat", 32'(heat_en), 32'd0);
    check("rst_cool", 32'(cool_en), 32'd0);
    check("rst_sw", 32'(sw), 32'd0);

    // Heat entry, minimum on-time, dead time, back to idle
    reset    = 1'b0;
    presence = 1'b1;
    temp     = 8'd15;
    tick(1);
    check("heat_entry_mode", 32'(mode), 32'd1);
    check("heat_entry_en", 32'(heat_en), 32'd1);
    check("heat_entry_cool", 32'(cool_en), 32'd0);
    check("heat_entry_sw", 32'(sw), 32'd1);
    tick(9);
    temp = 8'd20;
    tick(51);
    check("heat_hold_min_on", 32'(heat_en), 32'd1);
    tick(1);
    check("heat_release_mode", 32'(mode), 32'd3);
    check("heat_release_en", 32'(heat_en), 32'd0);
    tick(9);
    check("dead_last_cycle", 32'(mode), 32'd3);
    tick(1);
    check("dead_to_idle", 32'(mode), 32'd0);
    tick(1);
    check("idle_in_band", 32'(mode), 32'd0);

    // Cool entry, window forces exit before the minimum on-time
    temp = 8'd30;
    tick(1);
    check("cool_entry_mode", 32'(mode), 32'd2);
    check("cool_entry_en", 32'(cool_en), 32'd1);
    check("cool_entry_sw", 32'(sw), 32'd2);
    tick(4);
    window = 1'b1;
    tick(1);
    check("window_exit_mode", 32'(mode), 32'd3);
    check("window_exit_cool", 32'(cool_en), 32'd0);
    window = 1'b0;
    tick(9);
    check("dead_ignores_inputs", 32'(mode), 32'd3);
    tick(1);
    check("dead2_to_idle", 32'(mode), 32'd0);
    tick(1);
    check("cool_reentry_mode", 32'(mode), 32'd2);
    check("cool_reentry_sw", 32'(sw), 32'd3);

    // Cool -> heat must pass through dead time and idle
    temp = 8'd10;
    tick(60);
    check("cool_hold_min_on", 32'(mode), 32'd2);
    tick(1);
    check("cool_release_mode", 32'(mode), 32'd3);
    tick(9);
    check("c2h_dead_last", 32'(mode), 32'd3);
    tick(1);
    check("c2h_idle", 32'(mode), 32'd0);
    tick(1);
    check("c2h_heat_mode", 32'(mode), 32'd1);
    check("c2h_heat_en", 32'(heat_en), 32'd1);
    check("c2h_sw", 32'(sw), 32'd4);

    // Asynchronous reset pulse mid-cycle while heating
    #1 reset = 1'b1;
    #1;
    check("async_rst_heat", 32'(heat_en), 32'd0);
    check("async_rst_mode", 32'(mode), 32'd0);
    check("async_rst_sw", 32'(sw), 32'd0);
    #1 reset = 1'b0;
    tick(1);
    check("post_rst_heat_mode", 32'(mode), 32'd1);
    check("post_rst_sw", 32'(sw), 32'd1);

    // Losing presence exits heat immediately; reset inside dead time
    presence = 1'b0;
    tick(1);
    check("absent_exit_mode", 32'(mode), 32'd3);
    tick(2);
    check("in_dead_mode", 32'(mode), 32'd3);
    reset = 1'b1;
    #1;
    check("dead_rst_mode", 32'(mode), 32'd0);
    check("dead_rst_sw", 32'(sw), 32'd0);
    tick(1);
    reset = 1'b0;
    tick(1);
    check("idle_after_rst", 32'(mode), 32'd0);

    // Entry counter wrap
    force u_dut.switch_cnt = 16'hFFFF;
    tick(1);
    release u_dut.switch_cnt;
    check("sw_preload", 32'(sw), 32'h0000_FFFF);
    presence = 1'b1;
    temp     = 8'd30;
    tick(1);
    check("wrap_cool_mode", 32'(mode), 32'd2);
    check("sw_wrap", 32'(sw), 32'd0);

    // Wide thresholds: HEAT_ON+HYST=260 is unreachable at temp 255
    b_presence = 1'b1;
    b_temp     = 8'd100;
    tick(1);
    check("big_heat_entry", 32'(b_mode), 32'd1);
    b_temp = 8'd255;
    tick(10);
    check("big_no_release_mode", 32'(b_mode), 32'd1);
    check("big_no_release_en", 32'(b_heat_en), 32'd1);
    b_manual_off = 1'b1;
    tick(1);
    check("big_inhibit_exit", 32'(b_mode), 32'd3);
    tick(2);
    check("big_dead_last", 32'(b_mode), 32'd3);
    tick(1);
    check("big_idle", 32'(b_mode), 32'd0);

    check("no_overlap", 32'(overlap_seen), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
